// File: rtl/uart_cfg.sv
// Configurable-frame UART: DATA_BITS 5..9, optional odd/even parity, 1 or 2 stop bits.
// Independent TX and RX engines; RX reports framing and parity errors separately.
module uart_cfg #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic                 tx,
  input  logic                 transmit,
  input  logic [DATA_BITS-1:0] tx_byte,
  output logic                 received,
  output logic [DATA_BITS-1:0] rx_byte,
  output logic                 is_receiving,
  output logic                 is_transmitting,
  output logic                 recv_error,
  output logic                 parity_error,
  output logic [2:0]           recv_state,
  output logic [2:0]           tx_state
);

  localparam int            CW       = $clog2(2 * CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_BIT  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] CNT_STOP = CW'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [3:0]    LAST_BIT = 4'(DATA_BITS - 1);
  localparam logic          ODD      = (PARITY == 1);
  localparam logic          HAS_PAR  = (PARITY != 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4,
    S_ERROR  = 3'd5
  } state_t;

  state_t                tx_state_q, tx_state_d;
  logic [CW-1:0]         tx_cnt_q, tx_cnt_d;
  logic [3:0]            tx_bit_q, tx_bit_d;
  logic [DATA_BITS-1:0]  tx_shift_q, tx_shift_d;
  logic                  tx_par_q, tx_par_d;
  logic                  tx_accept;

  state_t                rx_state_q, rx_state_d;
  logic [CW-1:0]         rx_cnt_q, rx_cnt_d;
  logic [3:0]            rx_bit_q, rx_bit_d;
  logic [DATA_BITS-1:0]  rx_shift_q, rx_shift_d;
  logic                  rx_par_q, rx_par_d;
  logic [DATA_BITS-1:0]  rx_byte_q, rx_byte_d;
  logic                  rx_meta_q, rx_sync_q;
  logic                  received_q, received_d;
  logic                  rerr_q, rerr_d;
  logic                  perr_q, perr_d;

  // A request on the last stop cycle chains straight into the next START (no idle gap).
  assign tx_accept = transmit &&
                     ((tx_state_q == S_IDLE) || (tx_state_q == S_STOP && tx_cnt_q == '0));

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx         = 1'b1;
    case (tx_state_q)
      S_IDLE: ;
      S_START: begin
        tx = 1'b0;
        if (tx_cnt_q == '0) begin
          tx_state_d = S_DATA;
          tx_cnt_d   = CNT_BIT;
          tx_bit_d   = '0;
        end else tx_cnt_d = tx_cnt_q - 1'b1;
      end
      S_DATA: begin
        tx = tx_shift_q[0];
        if (tx_cnt_q == '0) begin
          tx_shift_d = tx_shift_q >> 1;
          tx_bit_d   = tx_bit_q + 4'd1;
          tx_cnt_d   = CNT_BIT;
          if (tx_bit_q == LAST_BIT) begin
            tx_state_d = HAS_PAR ? S_PARITY : S_STOP;
            tx_cnt_d   = HAS_PAR ? CNT_BIT : CNT_STOP;
          end
        end else tx_cnt_d = tx_cnt_q - 1'b1;
      end
      S_PARITY: begin
        tx = tx_par_q;
        if (tx_cnt_q == '0) begin
          tx_state_d = S_STOP;
          tx_cnt_d   = CNT_STOP;
        end else tx_cnt_d = tx_cnt_q - 1'b1;
      end
      S_STOP: begin
        if (tx_cnt_q == '0) tx_state_d = S_IDLE;
        else                tx_cnt_d   = tx_cnt_q - 1'b1;
      end
      default: tx_state_d = S_IDLE;
    endcase
    if (tx_accept) begin
      tx_state_d = S_START;
      tx_cnt_d   = CNT_BIT;
      tx_shift_d = tx_byte;
      tx_par_d   = (^tx_byte) ^ ODD;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
    end
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_par_d   = rx_par_q;
    rx_byte_d  = rx_byte_q;
    received_d = 1'b0;
    rerr_d     = 1'b0;
    perr_d     = 1'b0;
    case (rx_state_q)
      S_IDLE: begin
        if (!rx_sync_q) begin
          rx_state_d = S_START;
          rx_cnt_d   = CNT_HALF;
        end
      end
      S_START: begin
        if (rx_cnt_q != '0) rx_cnt_d = rx_cnt_q - 1'b1;
        else if (!rx_sync_q) begin
          rx_state_d = S_DATA;
          rx_cnt_d   = CNT_BIT;
          rx_bit_d   = '0;
        end else rx_state_d = S_IDLE;
      end
      S_DATA: begin
        if (rx_cnt_q == '0) begin
          rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
          rx_bit_d   = rx_bit_q + 4'd1;
          rx_cnt_d   = CNT_BIT;
          if (rx_bit_q == LAST_BIT) rx_state_d = HAS_PAR ? S_PARITY : S_STOP;
        end else rx_cnt_d = rx_cnt_q - 1'b1;
      end
      S_PARITY: begin
        if (rx_cnt_q == '0) begin
          rx_par_d   = rx_sync_q;
          rx_state_d = S_STOP;
          rx_cnt_d   = CNT_BIT;
        end else rx_cnt_d = rx_cnt_q - 1'b1;
      end
      S_STOP: begin
        if (rx_cnt_q != '0) rx_cnt_d = rx_cnt_q - 1'b1;
        else if (rx_sync_q) begin
          rx_state_d = S_IDLE;
          received_d = 1'b1;
          rx_byte_d  = rx_shift_q;
          perr_d     = HAS_PAR && (rx_par_q != ((^rx_shift_q) ^ ODD));
        end else begin
          rx_state_d = S_ERROR;
          rerr_d     = 1'b1;
          rx_cnt_d   = CNT_BIT;
        end
      end
      S_ERROR: begin
        // Any low cycle restarts the quiet-line window.
        if (!rx_sync_q)           rx_cnt_d   = CNT_BIT;
        else if (rx_cnt_q == '0)  rx_state_d = S_IDLE;
        else                      rx_cnt_d   = rx_cnt_q - 1'b1;
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rx_par_q   <= 1'b0;
      rx_byte_q  <= '0;
      received_q <= 1'b0;
      rerr_q     <= 1'b0;
      perr_q     <= 1'b0;
    end else begin
      rx_meta_q  <= rx;
      rx_sync_q  <= rx_meta_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
      rx_par_q   <= rx_par_d;
      rx_byte_q  <= rx_byte_d;
      received_q <= received_d;
      rerr_q     <= rerr_d;
      perr_q     <= perr_d;
    end
  end

  assign received        = received_q;
  assign rx_byte         = rx_byte_q;
  assign recv_error      = rerr_q;
  assign parity_error    = perr_q;
  assign recv_state      = rx_state_q;
  assign tx_state        = tx_state_q;
  assign is_receiving    = (rx_state_q != S_IDLE);
  assign is_transmitting = (tx_state_q != S_IDLE);

endmodule

// File: tb/tb_uart_cfg.sv
// Bench for uart_cfg: three instances (8N1, 8E2, 9O1) at 16 clocks/bit, checked
// against a bit-list frame model plus a last-byte scoreboard per instance.
module tb_uart_cfg;
  localparam int CPB = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [2:0] transmit_v, rx_drv, loop_v;
  logic [7:0] txb0, txb1;
  logic [8:0] txb2;
  wire  [7:0] rxb0, rxb1;
  wire  [8:0] rxb2;
  wire  [2:0] tx_w, rcv, isr, ist, rerr, perr;
  wire  [2:0] rs0, rs1, rs2, ts0, ts1, ts2;
  wire  [2:0] rx_in = (loop_v & tx_w) | (~loop_v & rx_drv);

  uart_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .rx(rx_in[0]), .tx(tx_w[0]), .transmit(transmit_v[0]),
    .tx_byte(txb0), .received(rcv[0]), .rx_byte(rxb0), .is_receiving(isr[0]),
    .is_transmitting(ist[0]), .recv_error(rerr[0]), .parity_error(perr[0]),
    .recv_state(rs0), .tx_state(ts0));
  uart_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) u1 (
    .clk(clk), .rst(rst), .rx(rx_in[1]), .tx(tx_w[1]), .transmit(transmit_v[1]),
    .tx_byte(txb1), .received(rcv[1]), .rx_byte(rxb1), .is_receiving(isr[1]),
    .is_transmitting(ist[1]), .recv_error(rerr[1]), .parity_error(perr[1]),
    .recv_state(rs1), .tx_state(ts1));
  uart_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(9), .PARITY(1), .STOP_BITS(1)) u2 (
    .clk(clk), .rst(rst), .rx(rx_in[2]), .tx(tx_w[2]), .transmit(transmit_v[2]),
    .tx_byte(txb2), .received(rcv[2]), .rx_byte(rxb2), .is_receiving(isr[2]),
    .is_transmitting(ist[2]), .recv_error(rerr[2]), .parity_error(perr[2]),
    .recv_state(rs2), .tx_state(ts2));

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int db(input int i);   return (i == 2) ? 9 : 8; endfunction
  function automatic int np(input int i);   return (i == 0) ? 0 : 1; endfunction
  function automatic int odd(input int i);  return (i == 2) ? 1 : 0; endfunction
  function automatic int ns(input int i);   return (i == 1) ? 2 : 1; endfunction
  function automatic int nbits(input int i); return 1 + db(i) + np(i) + ns(i); endfunction

  // Frame as a list of line levels: start, data LSB first, parity, stop(s).
  function automatic logic exp_bit(input int i, input int data, input int k);
    int ones;
    if (k == 0) return 1'b0;
    if (k <= db(i)) return logic'((data >> (k - 1)) & 1);
    if (np(i) == 1 && k == db(i) + 1) begin
      ones = $countones(data & ((1 << db(i)) - 1));
      return logic'((ones % 2) ^ odd(i));
    end
    return 1'b1;
  endfunction

  function automatic logic [8:0] get_rxb(input int i);
    case (i)
      0: return {1'b0, rxb0};
      1: return {1'b0, rxb1};
      default: return rxb2;
    endcase
  endfunction

  function automatic logic [2:0] get_rs(input int i);
    case (i)
      0: return rs0;
      1: return rs1;
      default: return rs2;
    endcase
  endfunction

  function automatic logic [2:0] get_ts(input int i);
    case (i)
      0: return ts0;
      1: return ts1;
      default: return ts2;
    endcase
  endfunction

  task automatic set_txb(input int i, input int d);
    case (i)
      0: txb0 = d[7:0];
      1: txb1 = d[7:0];
      default: txb2 = d[8:0];
    endcase
  endtask

  int n_recv[3] = '{0, 0, 0};
  int n_rerr[3] = '{0, 0, 0};
  int n_perr[3] = '{0, 0, 0};
  int n_palone[3] = '{0, 0, 0};
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rcv[i] === 1'b1) n_recv[i]++;
      if (rerr[i] === 1'b1) n_rerr[i]++;
      if (perr[i] === 1'b1) n_perr[i]++;
      if (perr[i] === 1'b1 && rcv[i] !== 1'b1) n_palone[i]++;
    end
  end

  task automatic send_check(input int i, input int data, input bit mid,
                            output logic par_seen, output int len);
    int f, errs;
    f = nbits(i) * CPB;
    errs = 0;
    len = 0;
    par_seen = 1'bx;
    @(negedge clk);
    transmit_v[i] = 1'b1;
    set_txb(i, data);
    @(negedge clk);
    transmit_v[i] = 1'b0;
    set_txb(i, ~data);
    for (int c = 0; c < f + 4; c++) begin
      if (c < f && tx_w[i] !== exp_bit(i, data, c / CPB)) errs++;
      if (c == (1 + db(i)) * CPB + CPB / 2) par_seen = tx_w[i];
      if (ist[i] === 1'b1) len++;
      if (mid && c == f / 2) begin
        transmit_v[i] = 1'b1;
        set_txb(i, data ^ 'h1FF);
      end
      if (mid && c == f / 2 + 1) transmit_v[i] = 1'b0;
      @(negedge clk);
    end
    check($sformatf("tx_wave[%0d]", i), errs, 0);
    check($sformatf("tx_len[%0d]", i), len, f);
    check($sformatf("tx_idle_high[%0d]", i), tx_w[i], 1);
  endtask

  task automatic drive_rx(input int i, input int data, input bit bp, input bit bs,
                          output logic [2:0] st_end);
    logic b;
    for (int k = 0; k < nbits(i); k++) begin
      b = exp_bit(i, data, k);
      if (bp && np(i) == 1 && k == db(i) + 1) b = ~b;
      if (bs && k > db(i) + np(i)) b = 1'b0;
      rx_drv[i] = b;
      repeat (CPB) @(negedge clk);
    end
    st_end = get_rs(i);
    rx_drv[i] = 1'b1;
  endtask

  task automatic run_case(input string name, input int i, input int data, input bit bp,
                          input bit bs, input bit lp, input int eb, input bit ep, input bit er);
    int r0, e0, p0, a0, len;
    logic [2:0] st;
    logic pb;
    r0 = n_recv[i]; e0 = n_rerr[i]; p0 = n_perr[i]; a0 = n_palone[i];
    if (lp) begin
      loop_v[i] = 1'b1;
      send_check(i, data, 1'b0, pb, len);
      st = get_rs(i);
    end else begin
      drive_rx(i, data, bp, bs, st);
    end
    repeat (40) @(negedge clk);
    loop_v[i] = 1'b0;
    check({name, ".recv_cnt"}, n_recv[i] - r0, er ? 0 : 1);
    check({name, ".rerr_cnt"}, n_rerr[i] - e0, er ? 1 : 0);
    check({name, ".perr_cnt"}, n_perr[i] - p0, ep ? 1 : 0);
    check({name, ".perr_alone"}, n_palone[i] - a0, 0);
    check({name, ".rx_byte"}, get_rxb(i), eb);
    check({name, ".state_at_end"}, st, er ? 5 : 0);
    check({name, ".state_idle"}, get_rs(i), 0);
  endtask

  typedef struct {
    int inst; int data; bit bp; bit bs; bit lp; int eb; bit ep; bit er;
  } vec_t;
  vec_t vecs[8];

  int   last_byte[3] = '{0, 0, 0};
  logic pb;
  int   len, r0, e0;
  logic saw;
  logic [2:0] st;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; transmit_v = '0; rx_drv = '1; loop_v = '0;
    txb0 = '0; txb1 = '0; txb2 = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("rst.tx[%0d]", i), tx_w[i], 1);
      check($sformatf("rst.tx_state[%0d]", i), get_ts(i), 0);
      check($sformatf("rst.recv_state[%0d]", i), get_rs(i), 0);
      check($sformatf("rst.rx_byte[%0d]", i), get_rxb(i), 0);
      check($sformatf("rst.flags[%0d]", i), {rcv[i], rerr[i], perr[i], ist[i], isr[i]}, 0);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);

    //            inst data    bp bs lp  exp_byte ep er
    vecs[0] = '{0, 'hAA,  0, 0, 1, 'hAA,  0, 0};
    vecs[1] = '{0, 'h55,  0, 0, 1, 'h55,  0, 0};
    vecs[2] = '{1, 'h55,  0, 0, 1, 'h55,  0, 0};
    vecs[3] = '{2, 'h1A5, 0, 0, 1, 'h1A5, 0, 0};
    vecs[4] = '{1, 'h55,  1, 0, 0, 'h55,  1, 0};
    vecs[5] = '{0, 'h3C,  0, 1, 0, 'h55,  0, 1};
    vecs[6] = '{2, 'h055, 1, 0, 0, 'h055, 1, 0};
    vecs[7] = '{1, 'hC3,  0, 1, 0, 'h55,  0, 1};
    for (int v = 0; v < 8; v++) begin
      run_case($sformatf("vec%0d", v), vecs[v].inst, vecs[v].data, vecs[v].bp, vecs[v].bs,
               vecs[v].lp, vecs[v].eb, vecs[v].ep, vecs[v].er);
      if (!vecs[v].er) last_byte[vecs[v].inst] = vecs[v].eb;
    end

    // Frame lengths and parity bit levels; the 8N1 send also pulses transmit mid-frame.
    send_check(0, 'hAA, 1'b1, pb, len);
    check("len_8n1", len, 160);
    send_check(1, 'h55, 1'b0, pb, len);
    check("len_8e2", len, 192);
    check("par_even_55", pb, 0);
    send_check(2, 'h055, 1'b0, pb, len);
    check("par_odd_055", pb, 1);

    // Back-to-back frames with transmit held high and tx_byte changed after acceptance.
    begin
      int errs, busy;
      errs = 0; busy = 0;
      @(negedge clk);
      transmit_v[0] = 1'b1;
      set_txb(0, 'h0F);
      @(negedge clk);
      set_txb(0, 'hF0);
      for (int c = 0; c < 2 * 160 + 4; c++) begin
        if (c < 320 && tx_w[0] !== exp_bit(0, (c < 160) ? 'h0F : 'hF0, (c % 160) / CPB)) errs++;
        if (ist[0] === 1'b1) busy++;
        if (c == 160) transmit_v[0] = 1'b0;
        @(negedge clk);
      end
      check("b2b.wave", errs, 0);
      check("b2b.busy", busy, 320);
    end

    // Short low glitch: START entered, then abandoned without any pulse.
    r0 = n_recv[0]; e0 = n_rerr[0]; saw = 1'b0;
    rx_drv[0] = 1'b0;
    for (int c = 0; c < 24; c++) begin
      if (c == 4) rx_drv[0] = 1'b1;
      if (isr[0] === 1'b1) saw = 1'b1;
      @(negedge clk);
    end
    check("glitch.seen", saw, 1);
    check("glitch.state", rs0, 0);
    check("glitch.pulses", (n_recv[0] - r0) + (n_rerr[0] - e0), 0);

    // ERROR holds until the line has been high long enough.
    drive_rx(0, 'h11, 1'b0, 1'b1, st);
    check("err.entry", st, 5);
    repeat (12) @(negedge clk);
    check("err.hold", rs0, 5);
    repeat (10) @(negedge clk);
    check("err.exit", rs0, 0);
    check("err.byte_kept", rxb0, last_byte[0]);

    for (int n = 0; n < 12; n++) begin
      int i, d, mode;
      bit bp, bs, lp;
      i = $urandom_range(0, 2);
      d = $urandom & ((1 << db(i)) - 1);
      mode = $urandom_range(0, 2);
      bp = (mode == 1 && np(i) == 1) ? bit'($urandom_range(0, 1)) : 1'b0;
      bs = (mode == 2);
      lp = (mode == 0);
      run_case($sformatf("rnd%0d", n), i, d, bp, bs, lp, bs ? last_byte[i] : d, bp, bs);
      if (!bs) last_byte[i] = d;
    end

    // Reset in the middle of a looped-back frame.
    @(negedge clk);
    loop_v[0] = 1'b1;
    transmit_v[0] = 1'b1;
    set_txb(0, 'h00);
    @(negedge clk);
    transmit_v[0] = 1'b0;
    repeat (40) @(negedge clk);
    check("pre_rst.tx_busy", ist[0], 1);
    check("pre_rst.rx_busy", isr[0], 1);
    rst = 1'b1;
    #1;
    check("mid_rst.tx", tx_w[0], 1);
    check("mid_rst.tx_state", ts0, 0);
    check("mid_rst.recv_state", rs0, 0);
    check("mid_rst.rx_byte", rxb0, 0);
    @(negedge clk);
    rst = 1'b0;
    loop_v[0] = 1'b0;
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_cfg.md
Name: uart_cfg

Overview:
- Parametrised successor to the fixed 8N1 team UART.
- Frame format is compile-time configurable: data width 5–9, parity none/odd/even, 1 or 2 stop bits, any integer bit period.
- Receiver reports framing and parity errors separately and exposes FSM states for debug.
- Sits between the host-side byte interface and the board RX/TX pins.

Parameters:
- CLKS_PER_BIT, 434: clk cycles per bit (50 MHz / 115200). Must be at least 4.
- DATA_BITS, 8: data bits per frame, legal range 5..9, sent LSB first.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  asynchronous, active-high reset.
- rx  in  1  serial input; asynchronous, idle high.
- tx  out  1  serial output; idle high.
- transmit  in  1  request to send tx_byte; sampled on posedge.
- tx_byte  in  DATA_BITS  data to send.
- received  out  1  one-cycle pulse when a frame completes with a valid stop bit.
- rx_byte  out  DATA_BITS  last received data; held until the next valid frame.
- is_receiving  out  1  high while recv_state != IDLE.
- is_transmitting  out  1  high while tx_state != IDLE.
- recv_error  out  1  one-cycle pulse on framing error.
- parity_error  out  1  one-cycle pulse, coincident with received, on parity mismatch.
- recv_state  out  3  0 IDLE, 1 START, 2 DATA, 3 PARITY, 4 STOP, 5 ERROR.
- tx_state  out  3  0 IDLE, 1 START, 2 DATA, 3 PARITY, 4 STOP.

Behaviour:
- Reset state: tx=1, all pulse outputs and flags 0, rx_byte=0, both FSMs IDLE, all counters 0. Reset asserted mid-frame aborts immediately; tx returns high in the same cycle.
- Parity bit: P = 1 if PARITY != 0, else 0. Even parity bit = XOR of data bits; odd = its inverse.
- Frame length: F = CLKS_PER_BIT*(1+DATA_BITS+P+STOP_BITS) cycles.

TX:
- In IDLE with transmit=1 at a posedge, latch tx_byte and enter START. tx goes low on the next cycle.
- START, each data bit, the parity bit and each stop bit each drive tx for exactly CLKS_PER_BIT cycles.
- PARITY state is skipped when PARITY=0. STOP drives tx=1 for STOP_BITS*CLKS_PER_BIT cycles, then IDLE.
- transmit is ignored while not IDLE. transmit held high continuously produces back-to-back frames with no idle gap. tx_byte changes after acceptance have no effect on the frame in flight.

RX:
- rx passes through a 2-flop synchroniser; all RX timing is relative to the synchronised signal.
- IDLE: a low level moves the FSM to START.
- START: wait CLKS_PER_BIT/2 cycles (integer divide).
  - rx still low: enter DATA.
  - rx high: glitch; return to IDLE, no outputs.
- DATA: sample every CLKS_PER_BIT cycles (mid-bit), shifting LSB first. After DATA_BITS samples go to PARITY, or to STOP if PARITY=0.
- PARITY: sample once and compare.
- STOP: sample the first stop bit only.
  - Sample is 1: the next cycle pulses received; rx_byte updates that same cycle; parity_error pulses alongside on mismatch and the data is still delivered. Return to IDLE.
  - Sample is 0: pulse recv_error; rx_byte is not updated and received does not pulse. Enter ERROR.
- ERROR: stay until the synchronised rx has been high for CLKS_PER_BIT consecutive cycles, then IDLE.
- A second stop bit is not checked; the receiver rearms after the first, so it tolerates senders using either STOP_BITS setting.
- TX and RX are fully independent. Simultaneous activity, including external loopback of tx to rx, is legal.

Test Plan:
- CLKS_PER_BIT=16, 8N1; xmit 0xAA -> tx low 16 cycles, then bits 0,1,0,1,0,1,0,1 at 16 cycles each, high ≥16 cycles. is_transmitting high for exactly 160 cycles.
- Loopback tx->rx, 8N1; send 0xAA then 0x55 -> two received pulses with rx_byte 0xAA then 0x55; recv_error and parity_error stay 0.
- PARITY=2, STOP_BITS=2; xmit 0x55 -> parity bit 0, frame 192 cycles. With PARITY=1 -> parity bit 1. Inject a flipped parity bit on rx -> received=1 and parity_error=1 in the same cycle, rx_byte=0x55.
- Drive an rx frame with stop bit 0 -> recv_error pulse, no received, rx_byte unchanged, recv_state=5 until rx held high 16 cycles, then 0.
- rx low glitch of 4 cycles -> recv_state returns to 0, no pulses. transmit asserted mid-frame -> ignored, frame unchanged.
- DATA_BITS=9; xmit 0x1A5 and loop back -> rx_byte=0x1A5. Assert rst mid-frame -> tx=1 and both states 0 immediately.
